// File: rtl/display_buffer_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_buffer_loader_pkg
// Purpose  : Constants shared by the display buffer loader, the VGA display
//            unit and the display line RAM.
//            Contents: data word width, probe address width, line count,
//            line address width, frame counter width and the loader FSM
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package display_buffer_loader_pkg;

  localparam int DIGIT     = 32;  // data word width
  localparam int ADDRWIDTH = 8;   // probe port word-address width
  localparam int LINES     = 32;  // lines copied per refresh (power of two)
  localparam int LINEWIDTH = 5;   // log2(LINES)
  localparam int FCWIDTH   = 8;   // completed-refresh counter width

  // Loader FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

endpackage : display_buffer_loader_pkg
`default_nettype wire

// File: rtl/display_buffer_loader.sv
`default_nettype none
// ============================================================================
// Module   : display_buffer_loader
// Purpose  : Frame-synchronous burst copy of LINES consecutive memory words,
//            starting at a latched word offset, into lines 0..LINES-1 of the
//            display line RAM.
// Ports    : CLK100MHZ   - clock, all state on rising edge
//            reset       - asynchronous active-low reset
//            start       - refresh request, sampled only in IDLE
//            base        - word offset of line 0, latched at accepted start
//            probe_addr  - registered word address to memory probe port
//            probe_data  - probe read data, valid one cycle after probe_addr
//            buf_we      - line RAM write enable
//            buf_addr    - line RAM write address
//            buf_wdata   - line RAM write data
//            busy        - high from accepted start through last write
//            done        - one-cycle pulse after the last write
//            frame_count - completed refreshes, wraps
// Revision : 1.0 - initial release
// ============================================================================
module display_buffer_loader
  import display_buffer_loader_pkg::*;
(
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base,
  output logic [ADDRWIDTH-1:0] probe_addr,
  input  logic [DIGIT-1:0]     probe_data,
  output logic                 buf_we,
  output logic [LINEWIDTH-1:0] buf_addr,
  output logic [DIGIT-1:0]     buf_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [FCWIDTH-1:0]   frame_count
);

  localparam logic [LINEWIDTH-1:0] c_last_line = LINEWIDTH'(LINES - 1);

  logic [1:0]           state_q,       state_d;
  logic [ADDRWIDTH-1:0] base_q,        base_d;
  logic [LINEWIDTH-1:0] rd_idx_q,      rd_idx_d;
  logic [ADDRWIDTH-1:0] probe_addr_q,  probe_addr_d;
  // Two-stage valid/index delay line covering the address register and the
  // synchronous read latency of the probe port.
  logic                 v1_q,          v1_d;
  logic [LINEWIDTH-1:0] idx1_q,        idx1_d;
  logic                 v2_q,          v2_d;
  logic [LINEWIDTH-1:0] idx2_q,        idx2_d;
  logic                 buf_we_q,      buf_we_d;
  logic [LINEWIDTH-1:0] buf_addr_q,    buf_addr_d;
  logic [DIGIT-1:0]     buf_wdata_q,   buf_wdata_d;
  logic                 done_q,        done_d;
  logic [FCWIDTH-1:0]   frame_count_q, frame_count_d;

  logic                 w_last_write;

  assign w_last_write = buf_we_q && (buf_addr_q == c_last_line);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    rd_idx_d      = rd_idx_q;
    probe_addr_d  = probe_addr_q;
    v1_d          = 1'b0;
    idx1_d        = idx1_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Line 0 is issued on the accepting edge so probe_addr = base
          // in the first busy cycle.
          state_d      = S_RUN;
          base_d       = base;
          probe_addr_d = base;
          v1_d         = 1'b1;
          idx1_d       = '0;
          rd_idx_d     = LINEWIDTH'(1);
        end
      end
      S_RUN: begin
        // Offset addition wraps silently at ADDRWIDTH bits.
        probe_addr_d = base_q + ADDRWIDTH'(rd_idx_q);
        v1_d         = 1'b1;
        idx1_d       = rd_idx_q;
        rd_idx_d     = rd_idx_q + LINEWIDTH'(1);
        if (rd_idx_q == c_last_line) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_write) begin
          state_d       = S_IDLE;
          done_d        = 1'b1;
          frame_count_d = frame_count_q + FCWIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    v2_d        = v1_q;
    idx2_d      = idx1_q;
    buf_we_d    = v2_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    if (v2_q) begin
      buf_addr_d  = idx2_q;
      buf_wdata_d = probe_data;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      rd_idx_q      <= '0;
      probe_addr_q  <= '0;
      v1_q          <= 1'b0;
      idx1_q        <= '0;
      v2_q          <= 1'b0;
      idx2_q        <= '0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= '0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      rd_idx_q      <= rd_idx_d;
      probe_addr_q  <= probe_addr_d;
      v1_q          <= v1_d;
      idx1_q        <= idx1_d;
      v2_q          <= v2_d;
      idx2_q        <= idx2_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign probe_addr  = probe_addr_q;
  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_wdata   = buf_wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule : display_buffer_loader
`default_nettype wire

// File: tb/tb_display_buffer_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_buffer_loader
// Purpose  : Self-checking bench for display_buffer_loader. A timeline model
//            (burst start edge + relative offset) predicts every output each
//            cycle; directed tests add literal expectations on the captured
//            line RAM contents and the frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_buffer_loader;
  import display_buffer_loader_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [ADDRWIDTH-1:0] base = '0;
  logic [ADDRWIDTH-1:0] probe_addr;
  logic [DIGIT-1:0]     probe_data = '0;
  logic                 buf_we;
  logic [LINEWIDTH-1:0] buf_addr;
  logic [DIGIT-1:0]     buf_wdata;
  logic                 busy;
  logic                 done;
  logic [FCWIDTH-1:0]   frame_count;

  display_buffer_loader dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .probe_addr (probe_addr),
    .probe_data (probe_data),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Memory behind the probe port (synchronous read) and line RAM capture.
  logic [DIGIT-1:0] mem [256];
  logic [DIGIT-1:0] ram [LINES];
  int               wcnt = 0;

  always @(posedge clk) probe_data <= mem[probe_addr];

  always @(posedge clk) begin
    if (reset && buf_we) begin
      ram[buf_addr] <= buf_wdata;
      wcnt = wcnt + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- timeline model ----------------
  // A burst accepted at edge t0 shapes the interval after edge t0+r:
  //   r in [0, LINES+1] busy, probe_addr = base + min(r, LINES-1)
  //   r in [2, LINES+1] write of line r-2
  //   r == LINES+2      done; frame counter already incremented
  // A new start is accepted when r >= LINES+3 (or no burst yet).
  int               cyc = 0;
  int               t0 = 0;
  bit               active = 0;
  int               mbase = 0;
  int               mfc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active = 0;
      mfc    = 0;
    end else begin
      cyc++;
      if (active && (cyc - t0) == LINES + 2) mfc = (mfc + 1) % 256;
      if (start && (!active || (cyc - t0) >= LINES + 3)) begin
        active = 1;
        t0     = cyc;
        mbase  = int'(base);
      end
    end
  end

  int               pa_h = 0;
  int               ba_h = 0;
  logic [DIGIT-1:0] bd_h = '0;

  always @(negedge clk) begin
    int  r;
    bit  busy_e, we_e, done_e;
    busy_e = 0; we_e = 0; done_e = 0;
    if (!reset) begin
      pa_h = 0; ba_h = 0; bd_h = '0;
    end else if (active) begin
      r      = cyc - t0;
      busy_e = (r <= LINES + 1);
      we_e   = (r >= 2) && (r <= LINES + 1);
      done_e = (r == LINES + 2);
      if (busy_e) pa_h = (mbase + ((r > LINES - 1) ? LINES - 1 : r)) % 256;
      if (we_e) begin
        ba_h = r - 2;
        bd_h = mem[(mbase + r - 2) % 256];
      end
    end
    chk("probe_addr",  64'(probe_addr),  64'(pa_h));
    chk("busy",        64'(busy),        64'(busy_e));
    chk("buf_we",      64'(buf_we),      64'(we_e));
    chk("buf_addr",    64'(buf_addr),    64'(ba_h));
    chk("buf_wdata",   64'(buf_wdata),   64'(bd_h));
    chk("done",        64'(done),        64'(done_e));
    chk("frame_count", 64'(frame_count), 64'(mfc));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [ADDRWIDTH-1:0] b);
    base  = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int w0;
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = DIGIT'(3 * i);

    // Reset held with start active and base toggling
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      base = ADDRWIDTH'(i * 37);
      tick(1);
    end
    chk("rst_no_writes", 64'(wcnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    tick(2);

    // Basic copy, mem[i] = 3i
    pulse_start(8'h00);
    tick(40);
    chk("basic_line0",  64'(ram[0]),  64'd0);
    chk("basic_line5",  64'(ram[5]),  64'd15);
    chk("basic_line31", 64'(ram[31]), 64'd93);
    chk("basic_wcnt",   64'(wcnt),    64'd32);
    chk("basic_fc",     64'(frame_count), 64'd1);

    // Address wrap, mem[i] = i
    for (int i = 0; i < 256; i++) mem[i] = DIGIT'(i);
    pulse_start(8'hF0);
    tick(40);
    chk("wrap_line15", 64'(ram[15]), 64'h0FF);
    chk("wrap_line16", 64'(ram[16]), 64'h000);
    chk("wrap_line31", 64'(ram[31]), 64'h00F);
    chk("wrap_fc",     64'(frame_count), 64'd2);

    // start/base ignored while busy
    w0 = wcnt;
    pulse_start(8'h10);
    tick(9);
    base  = 8'h40;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(45);
    chk("ign_wcnt",   64'(wcnt - w0), 64'd32);
    chk("ign_line0",  64'(ram[0]),  64'h10);
    chk("ign_line31", 64'(ram[31]), 64'h2F);
    chk("ign_fc",     64'(frame_count), 64'd3);
    chk("ign_idle",   64'(busy), 64'd0);

    // Reset during the write of line 10
    pulse_start(8'h20);
    tick(12);
    chk("mid_we",   64'(buf_we),   64'd1);
    chk("mid_addr", 64'(buf_addr), 64'd10);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",   64'(buf_we), 64'd0);
    chk("mid_rst_busy", 64'(busy),   64'd0);
    chk("mid_rst_fc",   64'(frame_count), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    pulse_start(8'h00);
    tick(40);
    chk("mid_line0",  64'(ram[0]),  64'd0);
    chk("mid_line31", 64'(ram[31]), 64'd31);
    chk("mid_fc",     64'(frame_count), 64'd1);

    // Back-to-back with start held high
    base  = 8'h80;
    start = 1'b1;
    tick(1 + 34);
    chk("b2b_fc1", 64'(frame_count), 64'd2);
    chk("b2b_done1", 64'(done), 64'd1);
    tick(35);
    chk("b2b_fc2", 64'(frame_count), 64'd3);
    tick(35);
    chk("b2b_fc3", 64'(frame_count), 64'd4);
    chk("b2b_done3", 64'(done), 64'd1);

    // Keep bursting until the frame counter wraps to zero
    guard = 0;
    while (frame_count != 8'd0 && guard < 256 * 35 + 100) begin
      tick(1);
      guard++;
    end
    chk("fc_wrap_reached", 64'(guard < 256 * 35 + 100), 64'd1);
    chk("fc_wrap_value", 64'(frame_count), 64'd0);
    chk("fc_wrap_done", 64'(done), 64'd1);
    start = 1'b0;
    tick(40);
    chk("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_display_buffer_loader
`default_nettype wire
